uart_tx_engine: RTL and testbench

Serial transmitter for the UART link: the transmit end of the frame format the UART receiver decodes. It accepts one parallel character per start/busy handshake and serializes it on `tx` LSB-first as a start bit, 5–8 data bits, an optional even/odd parity bit and 1–2 stop bits. Frame format is configured by the same per-frame controls the receiver uses. Transmission is gated by the peer's `cts_n`, so the block can drive a receiver's `rx` directly.

---
 rtl/uart_tx_engine.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// A request is taken only while the synchronized peer clear-to-send is low.
//
// state  | meaning
// IDLE   | line high, waiting for start_tx with cts_s low
// START  | start bit (line low)
// DATA   | data bits, bit_cnt selects the bit on the line
// PARITY | parity over the latched data bits
// STOP   | one or two stop bits, then back to IDLE with tx_done
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       cts_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic        cts_meta_q, cts_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  nbits_q, nbits_d;
  logic        stop2_q, stop2_d;
  logic        par_en_q, par_en_d;
  logic        par_type_q, par_type_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        baud_last;
  logic [2:0]  bit_nxt;
  logic [2:0]  last_idx;
  logic        par_bit;
  logic [7:0]  width_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_s_q    <= cts_meta_q;
    end
  end

  assign baud_last = (baud_cnt_q == BAUD_LAST);
  assign bit_nxt   = bit_cnt_q + 3'd1;
  assign last_idx  = {1'b0, nbits_q} + 3'd4;
  // data_q is masked at acceptance, so unused upper bits cannot disturb parity
  assign par_bit   = (^data_q) ^ par_type_q;

  always_comb begin
    width_mask = 8'hFF;
    case (data_bit_num)
      2'b00:   width_mask = 8'h1F;
      2'b01:   width_mask = 8'h3F;
      2'b10:   width_mask = 8'h7F;
      default: width_mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_last ? 16'd0 : baud_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    nbits_d    = nbits_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
        if (start_tx && !cts_s_q) begin
          state_d    = ST_START;
          data_d     = tx_data & width_mask;
          nbits_d    = data_bit_num;
          stop2_d    = stop_bit_num;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = data_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_cnt_q == last_idx) begin
            bit_cnt_d = 3'd0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_nxt;
            tx_d      = data_q[bit_nxt];
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d   = ST_STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (bit_cnt_q[0] == stop2_q) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      data_q     <= 8'd0;
      nbits_q    <= 2'd0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      nbits_q    <= nbits_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at CLKS_PER_BIT=4; frames are compared
// bit-by-bit against hand-derived line patterns (bit j = j-th bit on the wire).
module tb_uart_tx_engine;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       start_tx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       cts_n;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_engine #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .start_tx     (start_tx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                         input logic pe, input logic pt);
    tx_data      = d;
    data_bit_num = dbn;
    stop_bit_num = sb;
    parity_en    = pe;
    parity_type  = pt;
  endtask

  // Advance on negedges until tx_busy is seen; counts idle-high samples passed.
  task automatic wait_busy(input string tag, output int waited, output int idle_high);
    waited    = 0;
    idle_high = 0;
    while (tx_busy !== 1'b1 && waited < 100) begin
      if (tx === 1'b1) idle_high++;
      waited++;
      @(negedge clk);
    end
    if (tx_busy !== 1'b1) check({tag, "_busy_timeout"}, 32'(tx_busy), 32'd1);
  endtask

  // Called at the first busy sample; returns at the tx_done sample.
  task automatic capture(input string tag, input int nb, input logic [15:0] exp_word,
                         input bit drop_start, input bit raise_cts, output int tail_high);
    logic [15:0] obs = '0;
    int stable_err = 0;
    int busy_cnt   = 0;
    int done_in    = 0;
    tail_high = 0;
    for (int i = 0; i < nb * C; i++) begin
      if (i == 0 && drop_start) begin
        start_tx = 1'b0;
        set_cfg(~tx_data, ~data_bit_num, ~stop_bit_num, ~parity_en, ~parity_type);
      end
      if (raise_cts && i == 3 * C) cts_n = 1'b1;
      if (i % C == 0) obs[i / C] = tx;
      else if (tx !== obs[i / C]) stable_err++;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) done_in++;
      tail_high = (tx === 1'b1) ? tail_high + 1 : 0;
      @(negedge clk);
    end
    check({tag, "_bits"},      32'(obs),        32'(exp_word));
    check({tag, "_stable"},    32'(stable_err), 32'd0);
    check({tag, "_busy_len"},  32'(busy_cnt),   32'(nb * C));
    check({tag, "_done_early"},32'(done_in),    32'd0);
    check({tag, "_done"},      32'(tx_done),    32'd1);
    check({tag, "_busy_end"},  32'(tx_busy),    32'd0);
    check({tag, "_tx_end"},    32'(tx),         32'd1);
  endtask

  int waited, idle_high, tail, tail2, cnt;

  initial begin
    reset    = 1'b1;
    start_tx = 1'b0;
    cts_n    = 1'b0;
    set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_tx",   32'(tx),      32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    set_cfg(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    start_tx = 1'b1;
    wait_busy("8n1", waited, idle_high);
    capture("8n1", 10, 16'h034A, 1'b1, 1'b0, tail);
    @(negedge clk);
    check("8n1_done_once", 32'(tx_done), 32'd0);
    repeat (3) @(negedge clk);

    // 7E2 0x53: 0,1,1,0,0,1,0,1,0,1,1
    set_cfg(8'h53, 2'b10, 1'b1, 1'b1, 1'b0);
    start_tx = 1'b1;
    wait_busy("7e2", waited, idle_high);
    capture("7e2", 11, 16'h06A6, 1'b1, 1'b0, tail);
    repeat (3) @(negedge clk);

    // 5O1 0xFF: 0,1,1,1,1,1,0,1
    set_cfg(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1);
    start_tx = 1'b1;
    wait_busy("5o1", waited, idle_high);
    capture("5o1", 8, 16'h00BE, 1'b1, 1'b0, tail);
    repeat (3) @(negedge clk);

    // Flow control: held request with cts_n high, then release
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    set_cfg(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
    start_tx = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b1 && tx_busy === 1'b0) cnt++;
    end
    check("cts_blocked", 32'(cnt), 32'd50);
    cts_n = 1'b0;
    cnt   = 0;
    while (tx !== 1'b0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("cts_latency", 32'(cnt), 32'd3);
    // 0x3C: 0,0,0,1,1,1,1,0,0,1 ; cts_n raised during data
    capture("cts_mid", 10, 16'h0278, 1'b1, 1'b1, tail);
    cts_n = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with start_tx held
    set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
    start_tx = 1'b1;
    wait_busy("b2b_a", waited, idle_high);
    tx_data = 8'hFF;
    capture("b2b_a", 10, 16'h0200, 1'b0, 1'b0, tail);
    wait_busy("b2b_b", waited, idle_high);
    check("b2b_gap", 32'(waited), 32'd1);
    check("b2b_stop_len", 32'(tail + idle_high), 32'd5);
    capture("b2b_b", 10, 16'h03FE, 1'b1, 1'b0, tail2);
    repeat (3) @(negedge clk);

    // Reset 10 cycles into a frame
    set_cfg(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    start_tx = 1'b1;
    wait_busy("rst_mid", waited, idle_high);
    start_tx = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_tx",   32'(tx),      32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done === 1'b1) cnt++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx !== 1'b1) cnt++;
    end
    check("rst_mid_quiet", 32'(cnt), 32'd0);
    start_tx = 1'b1;
    wait_busy("post_rst", waited, idle_high);
    capture("post_rst", 10, 16'h034A, 1'b1, 1'b0, tail);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
